dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port Risc32 data memory between the CPU datapath load/store path and a debug/loader port.
- The debug/loader port preloads data and inspects memory without hierarchical pokes.
- Sits between the datapath, the debugger and the data memory array; 1-cycle read latency; round-robin with a debug lock mode.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte address width on both requester ports.
- MEM_ROWS, 32, data memory depth in words (power of 2); IDX_W = log2(MEM_ROWS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write enable (1 = store, 0 = load).
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt (combinational); freezes the PC.
- cpu_rvalid  out  1  CPU load data valid.
- cpu_rdata  out  DATA_W  CPU load data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request bundle, same meaning as the CPU bundle.
- dbg_lock  in  1  request exclusive ownership for the debug port.
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  debug responses.
- mem_en, mem_we  out  1/1  memory strobe and write enable.
- mem_idx  out  IDX_W  word index.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en & ~mem_we.

Behaviour:
- **Handshake:** the requester holds req, we, addr and wdata stable until it sees gnt high on a rising edge. A transfer completes on the cycle where req & gnt are both high. At most one gnt per cycle.
- **Memory outputs:** gnt and the mem_* outputs are combinational from the requests and the registered state. mem_en = cpu_gnt | dbg_gnt. mem_we, mem_idx and mem_wdata come from the granted port. Ungranted cycles drive mem_en=0, mem_we=0, mem_idx=0, mem_wdata=0.
- **Address mapping:** mem_idx = addr[IDX_W+1:2]. addr[1:0] and addr above IDX_W+1 are ignored, so addresses wrap modulo MEM_ROWS*4 bytes. Byte 124 maps to idx 31; byte 128 maps to idx 0.
- **Read return:** a registered rd_owner (NONE/CPU/DBG) is set when a read is granted. The next cycle pulses the owner's rvalid for 1 cycle with rdata = mem_rdata; the other port's rdata holds 0.
- **Back-to-back:** a grant may issue every cycle, including a read granted in the same cycle an earlier read returns. Writes never produce rvalid.
- **FSM state ARB (reset state):**
  - Round-robin using a registered last_owner, which resets to DBG so the CPU wins the first tie.
  - A single requester is granted immediately.
  - When both request, the port that is not last_owner wins.
  - A requester therefore waits at most 1 cycle.
- **FSM transition ARB -> LOCKED:** taken when dbg is granted with dbg_lock=1.
- **FSM state LOCKED:**
  - Only dbg may be granted; cpu_gnt=0, so cpu_stall follows cpu_req.
  - LOCKED -> ARB on the first cycle dbg_lock=0. That same cycle is arbitrated as ARB, with last_owner=DBG, so the CPU wins.
- **Simultaneous events:**
  - dbg_lock=1 without dbg_req while in ARB has no effect.
  - A write and a read from different ports in the same cycle resolve by normal arbitration; nothing is merged.
- **Reset:** asynchronous and may occur mid-operation.
  - Registered state goes to ARB, last_owner=DBG, rd_owner=NONE.
  - cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0.
  - Any pending read return is dropped; no rvalid follows reset.
  - With all requests low, every combinational output is 0.

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHECK_EN.
- With it defined:
  - Extra outputs cpu_misalign and dbg_misalign (1 bit each, registered, reset 0).
  - Each pulses for 1 cycle after a granted access with addr[1:0] != 0.
  - The access is still performed at the truncated word index.
- Without it: the ports are absent and addr[1:0] is silently ignored.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - owner_t enum (OWN_NONE, OWN_CPU, OWN_DBG);
  - arb_state_t enum (ARB, LOCKED);
  - the addr_to_idx function.
- One natural sub-module, rr_arbiter2: a 2-requester round-robin with last_owner register and an inhibit input used for LOCKED.

Test Plan:
1. CPU-only read: preload mem[1]=32'h7f7f, cpu read addr 4 -> cpu_gnt same cycle, cpu_rvalid next cycle with 32'h0000_7f7f, cpu_stall=0.
2. Wrap: dbg write 32'h8888_8888 at addr 124 and 32'hf7f7_7f7f at addr 128 -> mem_idx 31 and 0; cpu reads addr 0 -> rdata f7f7_7f7f.
3. Contention: cpu and dbg both read continuously for 6 cycles -> grants alternate CPU, DBG, CPU...; each rvalid goes to the correct port with matching data; cpu_stall high on DBG cycles.
4. Lock: dbg write with dbg_lock=1 for 4 cycles while cpu_req=1 -> cpu_gnt=0 and cpu_stall=1 throughout. On the first cycle dbg_lock=0, cpu_gnt=1 even with dbg_req=1.
5. Reset mid-read: read granted, rst_n low before the next edge -> no rvalid after release; state ARB; CPU wins the first tie.
6. DMEM_ARB_ALIGN_CHECK_EN defined: cpu read addr 6 -> mem_idx 1, cpu_misalign pulses 1 cycle. Macro undefined: same stimulus yields identical data with no misalign port.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and the byte-address to word-index helper for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Word index = byte address / 4, wrapped to the memory depth.
  function automatic logic [31:0] addr_to_idx(input logic [31:0] addr, input int unsigned idx_w);
    logic [31:0] w_mask;
    w_mask = (32'd1 << idx_w) - 32'd1;
    return (addr >> 2) & w_mask;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin (CPU vs debug) with a registered last owner.
// The inhibit input blocks the CPU side while the debug port holds the lock.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_cpu,
  input  logic i_req_dbg,
  input  logic i_inhibit_cpu,
  output logic o_gnt_cpu,
  output logic o_gnt_dbg
);

  owner_t r_last_owner;
  logic   w_gnt_cpu;
  logic   w_gnt_dbg;

  // CPU wins a tie only when it was not the previous owner.
  always_comb begin
    w_gnt_cpu = i_req_cpu & ~i_inhibit_cpu & (~i_req_dbg | (r_last_owner != OWN_CPU));
    w_gnt_dbg = i_req_dbg & ~w_gnt_cpu;
  end

  // Remember who was granted last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OWN_DBG;
    end else if (w_gnt_cpu) begin
      r_last_owner <= OWN_CPU;
    end else if (w_gnt_dbg) begin
      r_last_owner <= OWN_DBG;
    end else begin
      r_last_owner <= r_last_owner;
    end
  end

  assign o_gnt_cpu = w_gnt_cpu;
  assign o_gnt_dbg = w_gnt_dbg;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and the debug/loader port.
// Optional DMEM_ARB_ALIGN_CHECK_EN adds registered cpu_misalign/dbg_misalign flags.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int ADDR_W   = 32,
  parameter  int MEM_ROWS = 32,
  localparam int IDX_W    = $clog2(MEM_ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_idx,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  ,
  output logic              cpu_misalign,
  output logic              dbg_misalign
`endif
);

  arb_state_t       r_state;
  owner_t           r_rd_owner;
  logic             w_inhibit;
  logic             w_cpu_gnt;
  logic             w_dbg_gnt;
  logic [IDX_W-1:0] w_cpu_idx;
  logic [IDX_W-1:0] w_dbg_idx;

  // Lock only bites while held; the release cycle is arbitrated normally.
  assign w_inhibit = (r_state == LOCKED) & dbg_lock;

  rr_arbiter2 u_rr (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_cpu     (cpu_req),
    .i_req_dbg     (dbg_req),
    .i_inhibit_cpu (w_inhibit),
    .o_gnt_cpu     (w_cpu_gnt),
    .o_gnt_dbg     (w_dbg_gnt)
  );

  assign cpu_gnt   = w_cpu_gnt;
  assign dbg_gnt   = w_dbg_gnt;
  assign cpu_stall = cpu_req & ~w_cpu_gnt;
  assign w_cpu_idx = IDX_W'(addr_to_idx(32'(cpu_addr), IDX_W));
  assign w_dbg_idx = IDX_W'(addr_to_idx(32'(dbg_addr), IDX_W));

  // Memory strobe mux from the granted port; idle cycles drive all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = {IDX_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (w_cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_idx   = w_cpu_idx;
      mem_wdata = cpu_wdata;
    end else if (w_dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_idx   = w_dbg_idx;
      mem_wdata = dbg_wdata;
    end else begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_idx   = {IDX_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  // Lock FSM: enter on a locked debug grant, leave as soon as the lock drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
    end else begin
      case (r_state)
        ARB:     r_state <= (w_dbg_gnt & dbg_lock) ? LOCKED : ARB;
        LOCKED:  r_state <= dbg_lock ? LOCKED : ARB;
        default: r_state <= ARB;
      endcase
    end
  end

  // Tracks which port the memory read data returning next cycle belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner <= OWN_NONE;
    end else if (w_cpu_gnt & ~cpu_we) begin
      r_rd_owner <= OWN_CPU;
    end else if (w_dbg_gnt & ~dbg_we) begin
      r_rd_owner <= OWN_DBG;
    end else begin
      r_rd_owner <= OWN_NONE;
    end
  end

  // Read return steering; the non-owning port sees zero data.
  always_comb begin
    cpu_rvalid = (r_rd_owner == OWN_CPU);
    dbg_rvalid = (r_rd_owner == OWN_DBG);
    if (cpu_rvalid) begin
      cpu_rdata = mem_rdata;
    end else begin
      cpu_rdata = {DATA_W{1'b0}};
    end
    if (dbg_rvalid) begin
      dbg_rdata = mem_rdata;
    end else begin
      dbg_rdata = {DATA_W{1'b0}};
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  // One-cycle flag after a granted access whose byte offset is non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_misalign <= 1'b0;
      dbg_misalign <= 1'b0;
    end else begin
      cpu_misalign <= w_cpu_gnt & (cpu_addr[1:0] != 2'b00);
      dbg_misalign <= w_dbg_gnt & (dbg_addr[1:0] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a rule-level arbitration/memory model.
module tb_dmem_arbiter;

  localparam int W_NONE = 0;
  localparam int W_CPU  = 1;
  localparam int W_DBG  = 2;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [4:0]  mem_idx;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic        cpu_misalign, dbg_misalign;
`endif

  dmem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_idx    (mem_idx),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    ,
    .cpu_misalign (cpu_misalign),
    .dbg_misalign (dbg_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory array behind the arbiter: synchronous write, registered read.
  logic [31:0] ram [0:31];
  logic        ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int k = 0; k < 32; k++) ram[k] <= 32'd0;
      mem_rdata <= 32'd0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_idx] <= mem_wdata;
      else        mem_rdata    <= ram[mem_idx];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory contents, lock flag, previous winner, pending read returns.
  typedef struct { int due; bit is_cpu; logic [31:0] data; } rd_exp_t;
  rd_exp_t     rq[$];
  logic [31:0] ref_mem [0:31];
  bit          m_locked;
  int          m_prev;
  bit          m_mis_cpu, m_mis_dbg;

  // Monitor: every read return must match the oldest expected one, on time.
  always @(negedge clk) begin
    rd_exp_t e;
    if (cpu_rvalid || dbg_rvalid) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected: got cpu=%0b dbg=%0b expected none (cycle %0d)", cpu_rvalid, dbg_rvalid, cyc);
      end else begin
        e = rq.pop_front();
        chk("rvalid_port", 64'({cpu_rvalid, dbg_rvalid}), e.is_cpu ? 64'd2 : 64'd1);
        chk("rdata", e.is_cpu ? 64'(cpu_rdata) : 64'(dbg_rdata), 64'(e.data));
        chk("rdata_other_zero", e.is_cpu ? 64'(dbg_rdata) : 64'(cpu_rdata), 64'd0);
        chk("rvalid_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      e = rq.pop_front();
      checks++; errors++;
      $display("FAIL rvalid_missing: got none expected %s return of %h (cycle %0d)", e.is_cpu ? "cpu" : "dbg", e.data, cyc);
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, 64'({mem_en, mem_we, cpu_gnt, dbg_gnt, cpu_stall, cpu_rvalid, dbg_rvalid}), 64'd0);
    chk({tag, "_idx"}, 64'(mem_idx), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_rdata"}, {cpu_rdata, dbg_rdata}, 64'd0);
  endtask

  // One cycle: drive at posedge+1, check combinational outputs, advance the model.
  task automatic step(input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                      input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                      input logic dlock, output int win);
    int          e_idx;
    logic        e_we;
    logic [31:0] e_wd;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd; dbg_lock = dlock;
    #1;
    if (m_locked && dlock)   win = dreq ? W_DBG : W_NONE;
    else if (creq && dreq)   win = (m_prev == W_CPU) ? W_DBG : W_CPU;
    else if (creq)           win = W_CPU;
    else if (dreq)           win = W_DBG;
    else                     win = W_NONE;
    e_idx = 0; e_we = 1'b0; e_wd = 32'd0;
    if (win == W_CPU) begin
      e_idx = int'((caddr % 32'd128) / 32'd4); e_we = cwe; e_wd = cwd;
    end else if (win == W_DBG) begin
      e_idx = int'((daddr % 32'd128) / 32'd4); e_we = dwe; e_wd = dwd;
    end
    chk("cpu_gnt", 64'(cpu_gnt), 64'(win == W_CPU));
    chk("dbg_gnt", 64'(dbg_gnt), 64'(win == W_DBG));
    chk("cpu_stall", 64'(cpu_stall), 64'(creq && win != W_CPU));
    chk("mem_en", 64'(mem_en), 64'(win != W_NONE));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_idx", 64'(mem_idx), 64'(e_idx));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("cpu_misalign", 64'(cpu_misalign), 64'(m_mis_cpu));
    chk("dbg_misalign", 64'(dbg_misalign), 64'(m_mis_dbg));
`endif
    m_mis_cpu = (win == W_CPU) && (caddr % 32'd4 != 32'd0);
    m_mis_dbg = (win == W_DBG) && (daddr % 32'd4 != 32'd0);
    if (win != W_NONE) begin
      if (e_we) ref_mem[e_idx] = e_wd;
      else      rq.push_back('{due: cyc + 1, is_cpu: (win == W_CPU), data: ref_mem[e_idx]});
    end
    m_locked = (win == W_DBG && dlock) || (m_locked && dlock);
    if (win != W_NONE) m_prev = win;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int w;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, w);
  endtask

  task automatic model_reset();
    rq.delete();
    m_locked  = 1'b0;
    m_prev    = W_DBG;
    m_mis_cpu = 1'b0;
    m_mis_dbg = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int          w;
    bit          c_pend, d_pend, c_we, d_we;
    logic [31:0] c_a, c_d, d_a, d_d;
    int          lock_run;

    for (int k = 0; k < 32; k++) ref_mem[k] = 32'd0;
    model_reset();
    ram_clr = 1'b1;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0; dbg_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    ram_clr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // CPU-only read of a debug-preloaded word.
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd4, 32'h0000_7f7f, 1'b0, w);
    step(1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, w);
    idle(1);

    // Address wrap at the top of memory.
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd124, 32'h8888_8888, 1'b0, w);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd128, 32'hf7f7_7f7f, 1'b0, w);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, w);
    step(1'b1, 1'b0, 32'd124, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, w);

    // Continuous contention: both ports read every cycle.
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b0, 32'(4 * k), 32'd0, 1'b1, 1'b0, 32'(124 - 4 * k), 32'd0, 1'b0, w);
    idle(1);

    // Lock without a debug request has no effect; then a tie after it.
    step(1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, w);
    step(1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 32'd12, 32'd0, 1'b0, w);

    // Locked debug writes while the CPU waits, then release with both requesting.
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd16, 32'h1111_0000, 1'b1, w);
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b0, 32'd16, 32'd0, 1'b1, 1'b1, 32'(20 + 4 * k), 32'($urandom), 1'b1, w);
    step(1'b1, 1'b0, 32'd16, 32'd0, 1'b1, 1'b0, 32'd20, 32'd0, 1'b0, w);
    idle(2);

    // Misaligned access still uses the truncated word index.
    step(1'b1, 1'b0, 32'd6, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, w);
    idle(2);

    // Reset between a locked debug read grant and its return.
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b1, w);
    #1;
    rst_n = 1'b0;
    model_reset();
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
    cpu_addr = 32'd0; dbg_addr = 32'd0; cpu_wdata = 32'd0; dbg_wdata = 32'd0;
    #1;
    chk_idle("midreset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b1, w);
    idle(2);

    // Random traffic honouring the hold-until-granted handshake.
    c_pend = 1'b0; d_pend = 1'b0; lock_run = 0;
    c_we = 1'b0; d_we = 1'b0; c_a = 32'd0; c_d = 32'd0; d_a = 32'd0; d_d = 32'd0;
    for (int i = 0; i < 400; i++) begin
      if (!c_pend && $urandom_range(0, 3) != 0) begin
        c_pend = 1'b1; c_we = ($urandom_range(0, 1) == 1);
        c_a = 32'($urandom_range(0, 255)); c_d = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1; d_we = ($urandom_range(0, 1) == 1);
        d_a = 32'($urandom_range(0, 255)); d_d = $urandom;
      end
      if (lock_run > 0) lock_run--;
      else if ($urandom_range(0, 15) == 0) lock_run = $urandom_range(1, 5);
      step(c_pend, c_we, c_a, c_d, d_pend, d_we, d_a, d_d, (lock_run > 0), w);
      if (w == W_CPU) c_pend = 1'b0;
      if (w == W_DBG) d_pend = 1'b0;
    end
    idle(3);
    chk("scoreboard_drained", 64'(rq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
